// File: rtl/wb_fabric_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fabric_pkg
//  Description : Shared definitions for the Wishbone 1-to-N fabric:
//                FSM state encoding, error read-data value and the width of
//                the optional slave-ack timeout counter.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Read data returned to the master on unmapped or timed-out accesses
    localparam logic [7:0] ERR_DATA = 8'hFF;

    // Width of the slave-ack timeout counter
    localparam int TMO_CNT_W = 16;

endpackage : wb_fabric_pkg
`default_nettype wire

// File: rtl/wb_fabric_decode.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fabric_decode
//  Description : Purely combinational address decoder. Slave i matches when
//                (adr & MASK[i]) == (BASE[i] & MASK[i]); if several slaves
//                match, the lowest index wins.
//  Ports       : adr_i  - address to decode
//                hit_o  - at least one slave matched
//                sel_o  - one-hot select of the winning slave (0 on miss)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fabric_decode
    import wb_fabric_pkg::*;
#(
    parameter int                             N_SLAVES   = 8,
    parameter int                             ADDR_W     = 24,
    parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0]   adr_i,
    output logic                hit_o,
    output logic [N_SLAVES-1:0] sel_o
);

    logic [N_SLAVES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
            localparam logic [ADDR_W-1:0] C_BASE = SLAVE_BASE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] C_MASK = SLAVE_MASK[gi*ADDR_W +: ADDR_W];
            assign w_match[gi] = ((adr_i & C_MASK) == (C_BASE & C_MASK));
        end
    endgenerate

    // Lowest-index priority: keep only the first set bit of the match vector
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        sel_o   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_match[i] && !w_found) begin
                sel_o[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign hit_o = |w_match;

endmodule : wb_fabric_decode
`default_nettype wire

// File: rtl/wb_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fabric
//  Description : Single-master Wishbone fabric fanning out to N_SLAVES slaves.
//                The request is latched in IDLE and decoded; a hit strobes the
//                selected slave in ACTIVE until it acks, then RESP returns a
//                one-cycle m_ack_o with the captured data. A miss goes straight
//                to RESP with m_err_o=1 and data 8'hFF. Dropping m_cyc_i in
//                ACTIVE aborts without an ack.
//  Config      : WB_FABRIC_TIMEOUT_EN - when defined, an ACTIVE phase that sees
//                no ack for TIMEOUT_CYCLES cycles ends in an error response.
//  Ports       : clk, reset (async, active-high)
//                m_*  master side: adr/dat/we/sel/stb/cyc in, dat/ack/err out
//                s_*  slave side : latched adr/dat/we/sel, broadcast cyc,
//                                  one-hot stb out; per-slave dat/ack in
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fabric
    import wb_fabric_pkg::*;
#(
    parameter int                             N_SLAVES       = 8,
    parameter int                             ADDR_W         = 24,
    parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_BASE     = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0]     SLAVE_MASK     = '0,
    parameter int                             TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m_adr_i,
    input  logic [7:0]            m_dat_i,
    output logic [7:0]            m_dat_o,
    input  logic                  m_we_i,
    input  logic                  m_sel_i,
    input  logic                  m_stb_i,
    input  logic                  m_cyc_i,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [7:0]            s_dat_o,
    output logic                  s_we_o,
    output logic                  s_sel_o,
    output logic                  s_cyc_o,
    output logic [N_SLAVES-1:0]   s_stb_o,
    input  logic [N_SLAVES*8-1:0] s_dat_i,
    input  logic [N_SLAVES-1:0]   s_ack_i
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    adr_q,   adr_d;
    logic [7:0]           wdat_q,  wdat_d;
    logic                 we_q,    we_d;
    logic                 bsel_q,  bsel_d;
    logic [N_SLAVES-1:0]  slv_q,   slv_d;
    logic [7:0]           rdat_q,  rdat_d;
    logic                 err_q,   err_d;

    logic                 w_hit;
    logic [N_SLAVES-1:0]  w_sel;
    logic                 w_ack;
    logic [7:0]           w_rdat;
    logic                 w_expire;

    wb_fabric_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .adr_i (m_adr_i),
        .hit_o (w_hit),
        .sel_o (w_sel)
    );

    // Only the latched slave's ack counts; others are ignored
    assign w_ack = |(s_ack_i & slv_q);

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slv_q[i]) begin
                w_rdat = w_rdat | s_dat_i[i*8 +: 8];
            end
        end
    end

`ifdef WB_FABRIC_TIMEOUT_EN
    // Counter value during the last ACTIVE cycle before expiry: the count
    // reaches TIMEOUT_CYCLES as that cycle ends.
    localparam logic [TMO_CNT_W-1:0] C_TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ACTIVE) begin
            tmo_d = tmo_q + 1'b1;
        end else if (state_d == ACTIVE) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign w_expire = (tmo_q == C_TMO_LAST);
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        bsel_d  = bsel_q;
        slv_d   = slv_q;
        rdat_d  = rdat_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    adr_d  = m_adr_i;
                    wdat_d = m_dat_i;
                    we_d   = m_we_i;
                    bsel_d = m_sel_i;
                    slv_d  = w_sel;
                    if (w_hit) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = RESP;
                        rdat_d  = ERR_DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Priority: master abort, then slave ack, then timeout
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (w_ack) begin
                    state_d = RESP;
                    rdat_d  = w_rdat;
                    err_d   = 1'b0;
                end else if (w_expire) begin
                    state_d = RESP;
                    rdat_d  = ERR_DATA;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            bsel_q  <= 1'b0;
            slv_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            bsel_q  <= bsel_d;
            slv_q   <= slv_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign s_adr_o = adr_q;
    assign s_dat_o = wdat_q;
    assign s_we_o  = we_q;
    assign s_sel_o = bsel_q;
    assign s_cyc_o = (state_q == ACTIVE);
    assign s_stb_o = (state_q == ACTIVE) ? slv_q : '0;
    assign m_ack_o = (state_q == RESP);
    assign m_err_o = (state_q == RESP) && err_q;
    assign m_dat_o = rdat_q;

endmodule : wb_fabric
`default_nettype wire

// File: doc/wb_fabric.md
WB_FABRIC -- requirements
Module: wb_fabric

Interface
REQ-001 The block SHALL take parameter N_SLAVES, default 8: number of downstream Wishbone slaves, range 1-16.
REQ-002 The block SHALL take parameter ADDR_W, default 24: master and slave address width.
REQ-003 The block SHALL take parameter SLAVE_BASE, default all-zero, N_SLAVES*ADDR_W bits: per-slave match value; slave i occupies slice i.
REQ-004 The block SHALL take parameter SLAVE_MASK, default all-zero, N_SLAVES*ADDR_W bits: per-slave compare mask; a 1 bit means "compared".
REQ-005 The block SHALL take parameter TIMEOUT_CYCLES, default 255: slave-ack timeout, range 1-65535.
REQ-006 The block SHALL use a single clock and an asynchronous, active-high reset, exactly as already decided.
REQ-007 The block SHALL provide these ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- m_adr_i  in  ADDR_W  master address
- m_dat_i  in  8  master write data
- m_dat_o  out  8  master read data
- m_we_i  in  1  write enable
- m_sel_i  in  1  byte select
- m_stb_i  in  1  strobe
- m_cyc_i  in  1  cycle
- m_ack_o  out  1  acknowledge
- m_err_o  out  1  error (unmapped or timeout)
- s_adr_o  out  ADDR_W  latched address, broadcast to all slaves
- s_dat_o  out  8  latched write data
- s_we_o  out  1  latched write enable
- s_sel_o  out  1  latched byte select
- s_cyc_o  out  1  cycle, broadcast
- s_stb_o  out  N_SLAVES  one-hot strobe
- s_dat_i  in  N_SLAVES*8  slave read data; slave i occupies slice i
- s_ack_i  in  N_SLAVES  slave acknowledge

Function
REQ-008 The FSM SHALL have three states: IDLE, ACTIVE, RESP.
REQ-009 In IDLE, when m_cyc_i and m_stb_i are both high, the block SHALL latch address, write data, we and sel, and decode the address.
REQ-010 Decode SHALL select the lowest index i for which (m_adr_i & MASK[i]) == (BASE[i] & MASK[i]).
REQ-011 On a decode hit, the next state SHALL be ACTIVE.
REQ-012 On a decode miss, the next state SHALL be RESP with m_err_o=1 and m_dat_o=8'hFF.
REQ-013 In ACTIVE, s_cyc_o and s_stb_o[sel] SHALL be high and all other s_stb_o bits low.
REQ-014 In ACTIVE, on s_ack_i[sel], the block SHALL capture s_dat_i slice sel into the response register and go to RESP.
REQ-015 In ACTIVE, acks from unselected slaves SHALL be ignored.
REQ-016 In RESP, m_ack_o SHALL be high for exactly one cycle, together with m_dat_o and m_err_o; the next state SHALL be IDLE.
REQ-017 m_stb_i SHALL be ignored while in RESP.
REQ-018 Latency: a request sampled at edge 0 SHALL drive s_stb_o from cycle 1.
REQ-019 A slave ack sampled at edge k SHALL produce m_ack_o in cycle k+1.
REQ-020 The minimum read turnaround for a 0-wait slave SHALL be 3 cycles.
REQ-021 If m_cyc_i drops in ACTIVE, the block SHALL go to IDLE next cycle, drop the strobes, and issue no m_ack_o.
REQ-022 If m_cyc_i drops in the same cycle as the slave ack, the abort SHALL win.
REQ-023 m_dat_o SHALL hold its last response value outside RESP.
REQ-024 For writes, m_dat_o SHALL carry the captured slave data, which is don't-care for the master.

Reset
REQ-025 While reset is high, the FSM SHALL be IDLE, s_stb_o=0, s_cyc_o=0, m_ack_o=0, m_err_o=0, m_dat_o=8'h00, the latched address/data/we/sel registers 0, and the timeout counter 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ack.

Configuration
REQ-027 With macro WB_FABRIC_TIMEOUT_EN defined, a counter SHALL clear on entry to ACTIVE and increment each ACTIVE cycle.
REQ-028 With WB_FABRIC_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without an ack, the block SHALL drop the strobe and enter RESP with m_err_o=1 and m_dat_o=8'hFF.
REQ-029 With WB_FABRIC_TIMEOUT_EN defined, an ack in the same cycle as expiry SHALL win.
REQ-030 Without WB_FABRIC_TIMEOUT_EN, no counter SHALL exist, ACTIVE SHALL wait indefinitely, and m_err_o SHALL signal unmapped accesses only.

Structure
REQ-031 Package wb_fabric_pkg SHALL hold the state encoding (IDLE=2'd0, ACTIVE=2'd1, RESP=2'd2), the error data constant 8'hFF, and the timeout counter width constant (16).
REQ-032 Sub-module wb_fabric_decode SHALL be purely combinational: address in; hit flag and one-hot select out, with lowest-index priority.

Verification
REQ-033 Bench SHALL cover: N_SLAVES=4, BASE[1]=24'h010000, MASK[1]=24'hFF0000; read 24'h012345; slave 1 acks in cycle 1 with 8'h5A -> s_stb_o=4'b0010 in cycle 1, m_ack_o in cycle 2, m_dat_o=8'h5A, m_err_o=0.
REQ-034 Bench SHALL cover: address matching slaves 2 and 3 -> only s_stb_o[2] asserted.
REQ-035 Bench SHALL cover: access to 24'hF00000 with no match -> no s_stb_o, m_ack_o in cycle 1, m_err_o=1, m_dat_o=8'hFF.
REQ-036 Bench SHALL cover: macro defined, TIMEOUT_CYCLES=8, slave never acks -> strobe drops, m_ack_o and m_err_o high exactly once, 8 ACTIVE cycles after the strobe rises.
REQ-037 Bench SHALL cover: m_cyc_i dropped on the cycle slave 0 acks -> no m_ack_o, FSM back in IDLE next cycle, s_stb_o=0.
REQ-038 Bench SHALL cover: reset pulsed during ACTIVE -> all outputs 0 asynchronously, and the following request completes normally.
